// File: rtl/cordic_host_seq.sv
// ---------------------------------------------------------------------------
// cordic_host_seq
//
// Host-side sequencer that sits directly in front of the CORDIC top-level.
// It buffers I/Q sample pairs from a valid/ready source in a small FIFO.
// For each pair it drives the top-level load port: I in one cycle, then Q in
// the next, with Enable and IN_N_OUT high in both cycles. It then collects
// the two result words (amplitude first, phase second) from Data_out /
// Data_Ready and presents them together as one result beat with backpressure.
//
// Parameters:
//   W        sample / result word width
//   DEPTH    input FIFO depth in I/Q pairs (power of two, >= 2)
//   TIMEOUT  maximum wait cycles per result word (timeout build only)
//
// Ports:
//   CLK1, RST             clock, synchronous active-high reset
//   in_valid / in_ready   input pair handshake; in_ready = FIFO not full
//   in_I, in_Q            input sample pair (two's complement)
//   Data_in               word driven to the top-level
//   Enable                load strobe to the top-level
//   IN_N_OUT              1 = load phase, 0 = readback phase
//   Data_out, Data_Ready  result word and its one-cycle valid pulse
//   res_valid / res_ready result beat handshake
//   res_AM, res_PM        amplitude and phase of the held result
//   busy                  sequencer is not idle
//   done_cnt              completed-transaction counter (wraps at 256)
//   err                   sticky result-timeout flag
//
// Build option:
//   CORDIC_HOST_SEQ_TIMEOUT_EN  enables a per-word wait counter. When the
//   counter expires, err is set, the partial result is dropped and the
//   sequencer returns to IDLE. Without the macro the WAIT states wait
//   indefinitely and err is tied to 0.
//
// States:
//   state   | meaning
//   IDLE    | waiting for a buffered pair and a free result slot
//   LOAD_I  | driving I on the load port
//   LOAD_Q  | driving Q on the load port
//   WAIT_AM | waiting for the amplitude word
//   WAIT_PM | waiting for the phase word
// ---------------------------------------------------------------------------
module cordic_host_seq #(
    parameter int W       = 13,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         CLK1,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_I,
    input  logic [W-1:0] in_Q,
    output logic [W-1:0] Data_in,
    output logic         Enable,
    output logic         IN_N_OUT,
    input  logic [W-1:0] Data_out,
    input  logic         Data_Ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_AM,
    output logic [W-1:0] res_PM,
    output logic         busy,
    output logic [7:0]   done_cnt,
    output logic         err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_I  = 3'd1,
        LOAD_Q  = 3'd2,
        WAIT_AM = 3'd3,
        WAIT_PM = 3'd4
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [W-1:0]  mem_i [DEPTH];
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // A full FIFO refuses a push even when the sequencer pops in the same cycle.
    assign push     = in_valid && !full;
    // A new pair is only started once the previous result has been taken.
    assign pop      = (state == IDLE) && !empty && !res_valid;
    assign busy     = (state != IDLE);

    // The storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge CLK1) begin
        if (push) begin
            mem_i[wr_ptr] <= in_I;
            mem_q[wr_ptr] <= in_Q;
        end
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH by themselves.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered load-port and result outputs
    // ------------------------------------------------------------------
    logic [W-1:0] cur_q;

`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK1) begin
        if (RST) begin
            state     <= IDLE;
            Data_in   <= '0;
            Enable    <= 1'b0;
            IN_N_OUT  <= 1'b0;
            cur_q     <= '0;
            res_valid <= 1'b0;
            res_AM    <= '0;
            res_PM    <= '0;
            done_cnt  <= '0;
`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= LOAD_I;
                        Data_in  <= mem_i[rd_ptr];
                        cur_q    <= mem_q[rd_ptr];
                        Enable   <= 1'b1;
                        IN_N_OUT <= 1'b1;
                    end
                end

                LOAD_I: begin
                    state   <= LOAD_Q;
                    Data_in <= cur_q;
                end

                LOAD_Q: begin
                    // Data_in keeps Q through the readback phase.
                    state    <= WAIT_AM;
                    Enable   <= 1'b0;
                    IN_N_OUT <= 1'b0;
`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                WAIT_AM: begin
                    if (Data_Ready) begin
                        res_AM <= Data_out;
                        state  <= WAIT_PM;
`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end

                WAIT_PM: begin
                    // A word arriving on the expiry cycle still counts as a success.
                    if (Data_Ready) begin
                        res_PM    <= Data_out;
                        res_valid <= 1'b1;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= IDLE;
`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_host_seq.sv
// ---------------------------------------------------------------------------
// tb_cordic_host_seq
//
// Self-checking bench for cordic_host_seq. A behavioural stand-in for the
// CORDIC top-level captures the I and Q words from the load port. It returns
// the captured I as the amplitude word and the captured Q as the phase word.
// Expected results are queued when a pair is accepted and compared when the
// result beat is taken.
// ---------------------------------------------------------------------------
module tb_cordic_host_seq;

    localparam int W = 13;

    logic         CLK1 = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_I = '0;
    logic [W-1:0] in_Q = '0;
    logic [W-1:0] Data_in;
    logic         Enable;
    logic         IN_N_OUT;
    logic [W-1:0] Data_out = '0;
    logic         Data_Ready = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_AM;
    logic [W-1:0] res_PM;
    logic         busy;
    logic [7:0]   done_cnt;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK1 = ~CLK1;

    cordic_host_seq #(.W(W), .DEPTH(4), .TIMEOUT(10)) dut (
        .CLK1       (CLK1),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_I       (in_I),
        .in_Q       (in_Q),
        .Data_in    (Data_in),
        .Enable     (Enable),
        .IN_N_OUT   (IN_N_OUT),
        .Data_out   (Data_out),
        .Data_Ready (Data_Ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_AM     (res_AM),
        .res_PM     (res_PM),
        .busy       (busy),
        .done_cnt   (done_cnt),
        .err        (err)
    );

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic [W-1:0] am;
        logic [W-1:0] pm;
    } vec_t;

    vec_t vecs[5];

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e;

    bit model_en = 1'b1;
    int resp_gap = 1;
    int pm_gap   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stand-in for the CORDIC top-level.
    logic [W-1:0] mi, mq;
    bit got_i = 1'b0;
    always begin
        @(negedge CLK1);
        if (RST) begin
            got_i = 1'b0;
        end else if (model_en && Enable && IN_N_OUT) begin
            if (!got_i) begin
                mi = Data_in;
                got_i = 1'b1;
            end else begin
                mq = Data_in;
                got_i = 1'b0;
                repeat (resp_gap) @(negedge CLK1);
                Data_out = mi;
                Data_Ready = 1'b1;
                @(negedge CLK1);
                Data_Ready = 1'b0;
                repeat (pm_gap) @(negedge CLK1);
                Data_out = mq;
                Data_Ready = 1'b1;
                @(negedge CLK1);
                Data_Ready = 1'b0;
                Data_out = '0;
            end
        end
    end

    // Result monitor: scoreboard compare on handshake, stability while stalled.
    bit hold = 1'b0;
    logic [W-1:0] h_am, h_pm;
    always @(negedge CLK1) begin
        if (hold) begin
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_AM", 32'(res_AM), 32'(h_am));
            check("hold_res_PM", 32'(res_PM), 32'(h_pm));
        end
        hold = 1'b0;
        if (res_valid && !RST) begin
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: AM 0x%0h PM 0x%0h with nothing expected", res_AM, res_PM);
                end else begin
                    e = exp_q.pop_front();
                    check("res_AM", 32'(res_AM), 32'(e[2*W-1:W]));
                    check("res_PM", 32'(res_PM), 32'(e[W-1:0]));
                end
            end else begin
                hold = 1'b1;
                h_am = res_AM;
                h_pm = res_PM;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push_pair(input logic [W-1:0] i, input logic [W-1:0] q,
                             input logic [W-1:0] am, input logic [W-1:0] pm);
        int k;
        in_valid = 1'b1;
        in_I = i;
        in_Q = q;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge CLK1);
            #1;
            k++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready still 0 after %0d cycles", k);
        end else begin
            exp_q.push_back({am, pm});
        end
        @(posedge CLK1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || res_valid) && k < budget) begin
            @(negedge CLK1);
            k++;
        end
        if (exp_q.size() != 0 || res_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles", exp_q.size(), budget);
        end
        @(posedge CLK1);
        #1;
    endtask

    task automatic wait_wait_am();
        int k;
        k = 0;
        while (!(busy && !Enable) && k < 50) begin
            @(posedge CLK1);
            #1;
            k++;
        end
        check("reach_wait_state", 32'(busy && !Enable), 32'd1);
    endtask

    initial begin
        vecs[0] = '{i: 13'h0123, q: 13'h1F00, am: 13'h0123, pm: 13'h1F00};
        vecs[1] = '{i: 13'h0FFF, q: 13'h1000, am: 13'h0FFF, pm: 13'h1000};
        vecs[2] = '{i: 13'h1555, q: 13'h0AAA, am: 13'h1555, pm: 13'h0AAA};
        vecs[3] = '{i: 13'h0001, q: 13'h1FFF, am: 13'h0001, pm: 13'h1FFF};
        vecs[4] = '{i: 13'h0000, q: 13'h0042, am: 13'h0000, pm: 13'h0042};

        // Reset values
        RST = 1'b1;
        repeat (3) @(posedge CLK1);
        #1;
        RST = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_Enable", 32'(Enable), 32'd0);
        check("rst_IN_N_OUT", 32'(IN_N_OUT), 32'd0);
        check("rst_Data_in", 32'(Data_in), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_AM", 32'(res_AM), 32'd0);
        check("rst_res_PM", 32'(res_PM), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Load-port timing for a single pair
        res_ready = 1'b1;
        in_valid = 1'b1;
        in_I = 13'h0100;
        in_Q = 13'h0000;
        exp_q.push_back({13'h0100, 13'h0000});
        @(posedge CLK1);
        #1;
        in_valid = 1'b0;
        @(negedge CLK1);
        check("lat_t1_Enable", 32'(Enable), 32'd0);
        check("lat_t1_busy", 32'(busy), 32'd0);
        @(negedge CLK1);
        check("lat_load_i_Enable", 32'(Enable), 32'd1);
        check("lat_load_i_IN_N_OUT", 32'(IN_N_OUT), 32'd1);
        check("lat_load_i_Data_in", 32'(Data_in), 32'h0100);
        @(negedge CLK1);
        check("lat_load_q_Enable", 32'(Enable), 32'd1);
        check("lat_load_q_IN_N_OUT", 32'(IN_N_OUT), 32'd1);
        check("lat_load_q_Data_in", 32'(Data_in), 32'h0000);
        @(negedge CLK1);
        check("lat_wait_Enable", 32'(Enable), 32'd0);
        check("lat_wait_IN_N_OUT", 32'(IN_N_OUT), 32'd0);
        check("lat_wait_busy", 32'(busy), 32'd1);
        wait_drain(100);
        check("single_done_cnt", 32'(done_cnt), 32'd1);

        // Table-driven burst under backpressure: 1 in flight + 4 buffered
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_pair(vecs[k].i, vecs[k].q, vecs[k].am, vecs[k].pm);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (30) @(negedge CLK1);
        check("stall_res_valid", 32'(res_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_res_AM", 32'(res_AM), 32'(vecs[0].am));
        @(posedge CLK1);
        #1;
        res_ready = 1'b1;
        wait_drain(300);
        check("burst_done_cnt", 32'(done_cnt), 32'd6);
        check("burst_in_ready", 32'(in_ready), 32'd1);

        // Reset during WAIT_AM abandons the transaction
        model_en = 1'b0;
        push_pair(13'h0ABC, 13'h1555, 13'h0ABC, 13'h1555);
        wait_wait_am();
        RST = 1'b1;
        @(posedge CLK1);
        #1;
        RST = 1'b0;
        exp_q.delete();
        check("midrst_Enable", 32'(Enable), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        Data_out = 13'h0077;
        Data_Ready = 1'b1;
        @(posedge CLK1);
        #1;
        Data_out = 13'h0066;
        @(posedge CLK1);
        #1;
        Data_Ready = 1'b0;
        Data_out = '0;
        repeat (5) @(posedge CLK1);
        #1;
        check("ignored_dr_res_valid", 32'(res_valid), 32'd0);
        check("ignored_dr_busy", 32'(busy), 32'd0);
        check("ignored_dr_done_cnt", 32'(done_cnt), 32'd0);
        check("ignored_dr_res_AM", 32'(res_AM), 32'd0);
        model_en = 1'b1;

        // 256 transactions with varied response spacing: done_cnt wraps
        for (int n = 1; n <= 256; n++) begin
            logic [W-1:0] ri, rq;
            ri = W'($urandom);
            rq = W'($urandom);
            resp_gap = $urandom_range(1, 3);
            pm_gap = $urandom_range(0, 2);
            push_pair(ri, rq, ri, rq);
            wait_drain(100);
            if (n == 1)   check("wrap_done_cnt_1", 32'(done_cnt), 32'd1);
            if (n == 255) check("wrap_done_cnt_255", 32'(done_cnt), 32'd255);
        end
        check("wrap_done_cnt_0", 32'(done_cnt), 32'd0);
        resp_gap = 1;
        pm_gap = 0;

`ifdef CORDIC_HOST_SEQ_TIMEOUT_EN
        begin
            int k;
            model_en = 1'b0;
            push_pair(13'h0321, 13'h0123, 13'h0321, 13'h0123);
            wait_wait_am();
            k = 1;
            while (busy && k < 50) begin
                @(posedge CLK1);
                #1;
                k++;
            end
            exp_q.delete();
            check("to_wait_cycles", 32'(k - 1), 32'd10);
            check("to_err", 32'(err), 32'd1);
            check("to_res_valid", 32'(res_valid), 32'd0);
            check("to_done_cnt", 32'(done_cnt), 32'd0);
            model_en = 1'b1;
            push_pair(13'h0444, 13'h1333, 13'h0444, 13'h1333);
            wait_drain(100);
            check("to_after_done_cnt", 32'(done_cnt), 32'd1);
            check("to_err_sticky", 32'(err), 32'd1);
        end
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_host_seq.md
Name: cordic_host_seq

Overview:
- Host-side sequencer directly upstream of the CORDIC top-level.
- Buffers I/Q sample pairs from a valid/ready source and drives the top-level load port (Data_in, Enable, IN_N_OUT) in the CLK1 domain.
- Collects the two result words (amplitude, then phase) from Data_out/Data_Ready and presents them as one result beat with backpressure.

Parameters:
- W, 13, sample/result word width; matches the top-level Data_in/Data_out.
- DEPTH, 4, input FIFO depth in I/Q pairs; power of two, at least 2.
- TIMEOUT, 255, maximum wait cycles per result word; used only with the optional feature.

Ports:
- CLK1  in  1  clock; same domain as the top-level load port.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  source offers an I/Q pair.
- in_ready  out  1  FIFO can accept a pair.
- in_I  in  W  I sample, two's complement.
- in_Q  in  W  Q sample, two's complement.
- Data_in  out  W  word to the top-level.
- Enable  out  1  load strobe to the top-level.
- IN_N_OUT  out  1  1 = load phase, 0 = readback phase.
- Data_out  in  W  result word from the top-level.
- Data_Ready  in  1  one-cycle pulse per valid Data_out word.
- res_valid  out  1  result held.
- res_ready  in  1  sink accepts the result.
- res_AM  out  W  amplitude.
- res_PM  out  W  phase.
- busy  out  1  state is not IDLE.
- done_cnt  out  8  completed-transaction counter.
- err  out  1  sticky timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset, synchronous, active-high:
  - FIFO emptied; state IDLE.
  - Data_in=0, Enable=0, IN_N_OUT=0, res_valid=0, res_AM=0, res_PM=0, busy=0, done_cnt=0, err=0.
  - in_ready=1 in the first cycle after reset.
  - Reset asserted mid-transaction abandons it: no result, Enable low from the next edge.
- FIFO:
  - in_ready = !full (combinational). Push on in_valid && in_ready.
  - No push while full, even when a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, LOAD_I, LOAD_Q, WAIT_AM, WAIT_PM.
  - IDLE -> LOAD_I when the FIFO is non-empty and res_valid==0; the head pair is popped on that edge.
  - LOAD_I (1 cycle): Data_in=I, Enable=1, IN_N_OUT=1.
  - LOAD_Q (1 cycle): Data_in=Q, Enable=1, IN_N_OUT=1.
  - WAIT_AM: Enable=0, IN_N_OUT=0, Data_in holds Q. On Data_Ready, capture Data_out into res_AM, go to WAIT_PM.
  - WAIT_PM: on Data_Ready, capture into res_PM, set res_valid=1, done_cnt += 1 (255 wraps to 0), go to IDLE.
- Load-port outputs are registered and valid for the whole state cycle.
- Data_Ready is ignored in IDLE, LOAD_I and LOAD_Q.
- Data_Ready high on two consecutive cycles = two words: AM, then PM.
- Latency: pair pushed at edge t into an empty FIFO, idle block -> LOAD_I in cycle t+2, LOAD_Q in t+3, WAIT_AM from t+4.
- Result handshake:
  - res_valid, res_AM and res_PM stay stable until res_valid && res_ready.
  - res_valid clears on that edge; IDLE may pop the next pair on the following edge.
  - Back-to-back result rate is therefore at most one per 5+ cycles.
- busy = (state != IDLE).

Optional Feature:
- Macro: CORDIC_HOST_SEQ_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter clears on entry to WAIT_AM and WAIT_PM and increments each cycle in those states.
  - Counter reaching TIMEOUT with no Data_Ready: err=1 (sticky until RST), partial result discarded, res_valid not set, done_cnt unchanged, return to IDLE.
  - Data_Ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- Undefined: no counter; WAIT states wait indefinitely; err tied to 0.

Test Plan:
- Reset, then push I=0x0100, Q=0x0000 -> Enable=1 in cycles t+2 and t+3 with Data_in 0x0100 then 0x0000; IN_N_OUT=1 in both cycles, 0 afterwards.
- Model returns Data_Ready pulses with 0x0100 then 0x0000, res_ready=1 -> one beat, res_AM=0x0100, res_PM=0x0000, done_cnt=1.
- Push 5 pairs with res_ready=0 -> in_ready drops after the 5th push (1 in flight + 4 buffered); no second pop until the result is taken; then all 5 results appear in order.
- Assert RST during WAIT_AM -> next cycle Enable=0, busy=0, res_valid=0; a Data_Ready pulse arriving later is ignored.
- 256 completed transactions -> done_cnt wraps to 0.
- With CORDIC_HOST_SEQ_TIMEOUT_EN and TIMEOUT=10, withhold Data_Ready -> err=1 after 10 WAIT_AM cycles, return to IDLE, next pair still processed correctly.
